// File: rtl/mul_req_arbiter.sv
// Two-requester round-robin front end for a shared 8x8 multiplier.
// Optional WAIT watchdog enabled by defining MUL_REQ_ARBITER_TIMEOUT_EN.
module mul_req_arbiter #(
    parameter int TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_data,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_data,
    output logic        mul_start,
    output logic [15:0] mul_ip_BA,
    input  logic        mul_ready,
    input  logic [15:0] mul_op_prod,
    output logic        busy,
    output logic        grant_id,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic        last;
    logic        rsp_v;
    logic [15:0] rsp_q;
    logic        accept;
    logic        pick1;
    logic        rsp_done;

`ifdef MUL_REQ_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt;
    logic       terr;
    assign timeout_err = terr;
`else
    assign timeout_err = 1'b0;
`endif

    // On a tie the requester not served last wins; last resets to 1.
    always_comb begin
        pick1    = req1_valid && (!req0_valid || !last);
        accept   = reset && (state == IDLE) && (req0_valid || req1_valid);
        rsp_done = rsp_v && (grant_id ? rsp1_ready : rsp0_ready);
    end

    assign req0_ready = accept && !pick1;
    assign req1_ready = accept && pick1;
    assign rsp0_valid = rsp_v && !grant_id;
    assign rsp1_valid = rsp_v && grant_id;
    assign rsp0_data  = grant_id ? 16'h0000 : rsp_q;
    assign rsp1_data  = grant_id ? rsp_q : 16'h0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            rsp_v     <= 1'b0;
            rsp_q     <= 16'h0000;
            mul_start <= 1'b0;
            mul_ip_BA <= 16'h0000;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
`ifdef MUL_REQ_ARBITER_TIMEOUT_EN
            cnt       <= 8'd0;
            terr      <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id  <= pick1;
                        mul_ip_BA <= pick1 ? req1_data : req0_data;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
`ifdef MUL_REQ_ARBITER_TIMEOUT_EN
                        cnt       <= 8'd0;
                        terr      <= 1'b0;
`endif
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_ready) begin
                        rsp_q     <= mul_op_prod;
                        rsp_v     <= 1'b1;
                        mul_ip_BA <= 16'h0000;
                        state     <= RESP;
                    end
`ifdef MUL_REQ_ARBITER_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        rsp_q     <= 16'hFFFF;
                        rsp_v     <= 1'b1;
                        terr      <= 1'b1;
                        mul_ip_BA <= 16'h0000;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp_v <= 1'b0;
                        busy  <= 1'b0;
                        last  <= grant_id;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_req_arbiter.sv
// Directed bench for mul_req_arbiter: latency, round-robin, stalls,
// stray mul_ready, WAIT timeout/persistence and mid-transaction reset.
module tb_mul_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [15:0] rsp0_data, rsp1_data;
    logic        mul_start;
    logic [15:0] mul_ip_BA;
    logic        mul_ready;
    logic [15:0] mul_op_prod;
    logic        busy, grant_id, timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_req_arbiter #(.TIMEOUT(20)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .mul_start(mul_start), .mul_ip_BA(mul_ip_BA),
        .mul_ready(mul_ready), .mul_op_prod(mul_op_prod),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h1111;
        req1_valid = 1'b0; req1_data = 16'h0000;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        mul_ready = 1'b0;  mul_op_prod = 16'h0000;
        #3;
        chk("rst_req0_ready", 16'(req0_ready), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_grant", 16'(grant_id), 16'h0);
        chk("rst_ip", mul_ip_BA, 16'h0000);
        chk("rst_start", 16'(mul_start), 16'h0);
        chk("rst_rsp_v", {14'h0, rsp1_valid, rsp0_valid}, 16'h0);
        chk("rst_rsp_d", rsp0_data | rsp1_data, 16'h0000);
        chk("rst_terr", 16'(timeout_err), 16'h0);
        req0_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        step();

        // single request, minimum latency
        req0_valid = 1'b1; req0_data = 16'h0503;
        #1 chk("s1_ready0", 16'(req0_ready), 16'h1);
        chk("s1_ready1", 16'(req1_ready), 16'h0);
        step();
        req0_valid = 1'b0;
        chk("s1_start", 16'(mul_start), 16'h1);
        chk("s1_ip", mul_ip_BA, 16'h0503);
        chk("s1_grant", 16'(grant_id), 16'h0);
        chk("s1_busy", 16'(busy), 16'h1);
        step();
        chk("s1_start_once", 16'(mul_start), 16'h0);
        chk("s1_ip_wait", mul_ip_BA, 16'h0503);
        mul_ready = 1'b1; mul_op_prod = 16'h000F;
        step();
        mul_ready = 1'b0;
        chk("s1_rsp0_v", 16'(rsp0_valid), 16'h1);
        chk("s1_rsp0_d", rsp0_data, 16'h000F);
        chk("s1_rsp1_v", 16'(rsp1_valid), 16'h0);
        chk("s1_ip_resp", mul_ip_BA, 16'h0000);
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        chk("s1_idle_busy", 16'(busy), 16'h0);
        chk("s1_idle_rsp0", 16'(rsp0_valid), 16'h0);

        // fresh reset, then tie
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        req0_valid = 1'b1; req0_data = 16'hFFFF;
        req1_valid = 1'b1; req1_data = 16'h0202;
        #1 chk("s2_tie_r0", 16'(req0_ready), 16'h1);
        chk("s2_tie_r1", 16'(req1_ready), 16'h0);
        step();
        req0_valid = 1'b0;
        chk("s2_stall_r1", 16'(req1_ready), 16'h0);
        chk("s2_ip0", mul_ip_BA, 16'hFFFF);
        step();
        mul_ready = 1'b1; mul_op_prod = 16'hFE01;
        step();
        mul_ready = 1'b0;
        chk("s2_rsp0_d", rsp0_data, 16'hFE01);
        chk("s2_rsp0_v", 16'(rsp0_valid), 16'h1);
        rsp0_ready = 1'b1;
        #1 chk("s2_resp_r1", 16'(req1_ready), 16'h0);
        step();
        rsp0_ready = 1'b0;
        #1 chk("s2_idle_r1", 16'(req1_ready), 16'h1);
        step();
        req1_valid = 1'b0;
        chk("s2_grant1", 16'(grant_id), 16'h1);
        chk("s2_ip1", mul_ip_BA, 16'h0202);
        step();
        mul_ready = 1'b1; mul_op_prod = 16'h0004;
        step();
        mul_ready = 1'b0;
        chk("s2_rsp1_v", 16'(rsp1_valid), 16'h1);
        chk("s2_rsp1_d", rsp1_data, 16'h0004);
        chk("s2_rsp0_off", 16'(rsp0_valid), 16'h0);

        // rsp1 back-pressure with req0 waiting
        req0_valid = 1'b1; req0_data = 16'h0304;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("s3_hold_v", 16'(rsp1_valid), 16'h1);
            chk("s3_hold_d", rsp1_data, 16'h0004);
            chk("s3_stall_r0", 16'(req0_ready), 16'h0);
            step();
        end
        rsp1_ready = 1'b1;
        #1 chk("s3_hs_r0", 16'(req0_ready), 16'h0);
        step();
        rsp1_ready = 1'b0;
        chk("s3_done_v", 16'(rsp1_valid), 16'h0);

        // tie after requester 1 served; stray mul_ready in IDLE
        req1_valid = 1'b1; req1_data = 16'h0101;
        mul_ready = 1'b1; mul_op_prod = 16'hBEEF;
        #1 chk("s3_tie_r0", 16'(req0_ready), 16'h1);
        chk("s3_tie_r1", 16'(req1_ready), 16'h0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("s4_grant0", 16'(grant_id), 16'h0);
        chk("s4_ip", mul_ip_BA, 16'h0304);
        mul_op_prod = 16'h1234;
        step();
        mul_ready = 1'b0;
        chk("s4_wait_ip", mul_ip_BA, 16'h0304);
        step();
        chk("s4_no_rsp", 16'(rsp0_valid), 16'h0);
        chk("s4_busy", 16'(busy), 16'h1);
        mul_ready = 1'b1; mul_op_prod = 16'h000C;
        step();
        mul_ready = 1'b0;
        chk("s4_rsp_v", 16'(rsp0_valid), 16'h1);
        chk("s4_rsp_d", rsp0_data, 16'h000C);
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        chk("s4_idle", 16'(busy), 16'h0);

        // multiplier never answers
        req1_valid = 1'b1; req1_data = 16'h0A0B;
        step();
        req1_valid = 1'b0;
        step();
`ifdef MUL_REQ_ARBITER_TIMEOUT_EN
        repeat (19) step();
        chk("s5_pre_to", 16'(rsp1_valid), 16'h0);
        step();
        chk("s5_to_v", 16'(rsp1_valid), 16'h1);
        chk("s5_to_d", rsp1_data, 16'hFFFF);
        chk("s5_to_err", 16'(timeout_err), 16'h1);
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        chk("s5_err_held", 16'(timeout_err), 16'h1);
        req0_valid = 1'b1; req0_data = 16'h0203;
        step();
        req0_valid = 1'b0;
        chk("s5_err_clr", 16'(timeout_err), 16'h0);
        step();
`else
        repeat (1000) step();
        chk("s5_still_busy", 16'(busy), 16'h1);
        chk("s5_no_rsp", 16'(rsp1_valid), 16'h0);
        chk("s5_ip", mul_ip_BA, 16'h0A0B);
        chk("s5_terr", 16'(timeout_err), 16'h0);
`endif

        // reset during WAIT
        reset = 1'b0;
        #1;
        chk("s6_busy", 16'(busy), 16'h0);
        chk("s6_ip", mul_ip_BA, 16'h0000);
        chk("s6_grant", 16'(grant_id), 16'h0);
        chk("s6_rsp_v", {14'h0, rsp1_valid, rsp0_valid}, 16'h0);
        chk("s6_start", 16'(mul_start), 16'h0);
        chk("s6_terr", 16'(timeout_err), 16'h0);
        step();
        reset = 1'b1;
        mul_ready = 1'b1; mul_op_prod = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s6_no_rsp", {14'h0, rsp1_valid, rsp0_valid}, 16'h0);
            chk("s6_idle", 16'(busy), 16'h0);
        end
        mul_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_req_arbiter.md
MUL_REQ_ARBITER -- requirements
Module: mul_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 200: maximum number of WAIT cycles allowed for mul_ready (8-bit counter).
REQ-002 clk  input  1  clock; all logic on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 (UART side) has an operand pair.
REQ-005 req0_data  input  16  operands: [15:8]=B, [7:0]=A.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-007 rsp0_valid / rsp0_ready / rsp0_data  output / input / output  1 / 1 / 16  product return channel for requester 0.
REQ-008 req1_valid, req1_data, req1_ready, rsp1_valid, rsp1_ready, rsp1_data  same directions and widths as REQ-004..007, for requester 1 (SPI side).
REQ-009 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-010 mul_ip_BA  output  16  operands driven to the multiplier.
REQ-011 mul_ready  input  1  multiplier result valid.
REQ-012 mul_op_prod  input  16  multiplier product.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant_id  output  1  requester currently being served.
REQ-015 timeout_err  output  1  last transaction ended by timeout.

Function
REQ-016 FSM states: IDLE, START, WAIT, RESP; IDLE is the only state that accepts requests.
REQ-017 In IDLE with at least one reqN_valid, the arbiter combinationally raises reqN_ready for exactly one winner, latches reqN_data into an operand register, sets grant_id to the winner and moves to START.
REQ-018 Arbitration is round-robin: if only one requester is valid, it wins; if both are valid, the requester not served last wins; after reset, requester 0 has priority.
REQ-019 In START, mul_start=1 for exactly one cycle, then the FSM moves to WAIT.
REQ-020 mul_ip_BA equals the operand register from START through the end of WAIT, and is 0 in IDLE.
REQ-021 In WAIT, on the first cycle with mul_ready=1, mul_op_prod is latched into the response register and the FSM moves to RESP.
REQ-022 mul_ready asserted in any state other than WAIT is ignored.
REQ-023 In RESP, rspN_valid (N=grant_id) is held high with rspN_data stable until rspN_ready=1; in that cycle the FSM returns to IDLE and the round-robin pointer records N.
REQ-024 The non-granted rsp channel keeps rsp_valid=0 at all times.
REQ-025 Minimum latency: request handshake in cycle T, mul_start in T+1, mul_ready at T+2, rsp_valid from T+3.
REQ-026 A request arriving while busy=1 is stalled (ready=0) and is never dropped; the requester holds valid.
REQ-027 Back-to-back operation: IDLE may accept a new request in the cycle after the RESP handshake.
REQ-028 timeout_err clears on each new accept.

Reset
REQ-029 reset=0 forces, asynchronously: state=IDLE; mul_start=0, mul_ip_BA=0, req0/1_ready=0, rsp0/1_valid=0, rsp0/1_data=0, busy=0, grant_id=0, timeout_err=0; round-robin pointer set so requester 0 wins ties; timeout counter=0.
REQ-030 Reset asserted mid-transaction abandons the transaction; no response is produced for it after reset is released.

Configuration
REQ-031 Macro MUL_REQ_ARBITER_TIMEOUT_EN, when defined: the WAIT counter increments each cycle; if it reaches TIMEOUT without mul_ready, the FSM goes to RESP with response data 16'hFFFF and sets timeout_err=1.
REQ-032 When MUL_REQ_ARBITER_TIMEOUT_EN is not defined: no counter is built, WAIT persists until mul_ready, and timeout_err is tied to 0.

Verification
REQ-033 The bench covers these directed scenarios:
- req0 0x0503, multiplier mul_ready 1 cycle after start returning 0x000F -> mul_start pulses once, mul_ip_BA=0x0503, rsp0_data=0x000F at T+3, grant_id=0.
- req0 and req1 valid in the same cycle after reset (0xFFFF, 0x0202) -> requester 0 served first (rsp 0xFE01), then requester 1 (rsp 0x0004); on the next tie, requester 0 wins again because requester 1 was served last.
- rsp1_ready held low 10 cycles -> rsp1_valid and rsp1_data stay stable; req0 asserted meanwhile sees req0_ready=0 until the RESP handshake completes.
- mul_ready pulsed while in IDLE and in START -> ignored; the product is captured only in WAIT.
- With MUL_REQ_ARBITER_TIMEOUT_EN and TIMEOUT=20, mul_ready never asserted -> RESP after 20 WAIT cycles with data 0xFFFF and timeout_err=1; without the macro the FSM is still in WAIT after 1000 cycles.
- reset pulsed during WAIT -> all outputs return to reset values immediately, and no rsp_valid appears after release.
